// File: rtl/adsr_poly_pkg.sv
// Shared types for the ADSR envelope family: phases, fixed-point word and
// the level-to-amplitude conversion used at the VCA boundary.
package mypackage;

  typedef logic [15:0] amplitude;

  localparam int AMP_BITS              = $bits(amplitude);
  localparam int FIXED_TOTAL_BITS      = 48;
  localparam int FIXED_FRACTIONAL_BITS = 32;
  localparam int LEVEL_MAX_BITS        = 64;

  typedef logic signed [FIXED_TOTAL_BITS-1:0] fixed_t;

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } adsr_phase;

  // Top amplitude bits just below the binary point; full scale saturates to all-ones.
  function automatic amplitude amplitude_from_level(input logic [LEVEL_MAX_BITS-1:0] level,
                                                    input int unsigned frac_bits);
    logic [LEVEL_MAX_BITS-1:0] one;
    one = LEVEL_MAX_BITS'(1) << frac_bits;
    if (level >= one) return '1;
    return amplitude'(level >> (frac_bits - AMP_BITS));
  endfunction

endpackage

// File: rtl/adsr_poly_step.sv
// Combinational single-tick envelope update for one voice; shared by all
// voices through the slot multiplexer in adsr_poly.
module adsr_step
  import mypackage::*;
#(
  parameter int TOTAL_BITS      = 48,
  parameter int FRACTIONAL_BITS = 32
) (
  input  logic [TOTAL_BITS-1:0] level,
  input  adsr_phase             phase,
  input  logic                  gate,
  input  logic                  gate_q,
  input  logic                  legato,
  input  logic [TOTAL_BITS-1:0] a,
  input  logic [TOTAL_BITS-1:0] d,
  input  logic [TOTAL_BITS-1:0] s,
  input  logic [TOTAL_BITS-1:0] r,
  output logic [TOTAL_BITS-1:0] next_level,
  output adsr_phase             next_phase
);

  // One guard bit so level + a and s + d never wrap.
  localparam int W = TOTAL_BITS + 1;
  localparam logic [W-1:0] ONE_W = W'(1) << FRACTIONAL_BITS;

  logic           rise;
  logic [W-1:0]   base;
  logic [W-1:0]   a_w;
  logic [W-1:0]   d_w;
  logic [W-1:0]   s_w;
  logic [W-1:0]   r_w;
  adsr_phase      work;

  always_comb begin
    rise = gate & ~gate_q;
    a_w  = {1'b0, a};
    d_w  = {1'b0, d};
    s_w  = {1'b0, s};
    r_w  = {1'b0, r};
    base = {1'b0, level};
    work = phase;

    // A key-down restarts the attack within the same tick it is seen.
    if (rise) begin
      work = ATTACK;
      if (!legato) base = '0;
    end

    next_level = base[TOTAL_BITS-1:0];
    next_phase = work;

    if (!gate && (work == ATTACK || work == DECAY || work == SUSTAIN)) begin
      next_phase = RELEASE;
    end else begin
      case (work)
        IDLE: begin
          next_level = '0;
        end
        ATTACK: begin
          if (base + a_w >= ONE_W) begin
            next_level = ONE_W[TOTAL_BITS-1:0];
            next_phase = DECAY;
          end else begin
            next_level = TOTAL_BITS'(base + a_w);
          end
        end
        DECAY: begin
          // Comparing against s + d avoids underflow when level < d.
          if (base <= s_w + d_w) begin
            next_level = s;
            next_phase = SUSTAIN;
          end else begin
            next_level = TOTAL_BITS'(base - d_w);
          end
        end
        SUSTAIN: begin
          next_level = s;
        end
        RELEASE: begin
          if (base <= r_w) begin
            next_level = '0;
            next_phase = IDLE;
          end else begin
            next_level = TOTAL_BITS'(base - r_w);
          end
        end
        default: begin
          next_level = '0;
          next_phase = IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/adsr_poly.sv
// Polyphonic ADSR: VOICES envelopes sharing one patch, updated one voice per
// clock through a single adsr_step datapath once per sample strobe.
module adsr_poly
  import mypackage::*;
#(
  parameter int TOTAL_BITS      = 48,
  parameter int FRACTIONAL_BITS = 32,
  parameter int VOICES          = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_en,
  input  logic signed [TOTAL_BITS-1:0] a,
  input  logic signed [TOTAL_BITS-1:0] d,
  input  logic signed [TOTAL_BITS-1:0] s,
  input  logic signed [TOTAL_BITS-1:0] r,
  input  logic                         legato,
  input  logic [VOICES-1:0]            gate,
  output amplitude [VOICES-1:0]        out,
  output logic [VOICES-1:0]            active,
  output logic                         busy,
  output logic                         done
);

  localparam int SLOT_BITS = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [SLOT_BITS-1:0]  LAST_SLOT = SLOT_BITS'(VOICES - 1);
  localparam logic [TOTAL_BITS-1:0] ONE       = TOTAL_BITS'(1) << FRACTIONAL_BITS;

  typedef enum logic {
    PASS_IDLE,
    PASS_RUN
  } pass_state;

  pass_state               state_q;
  pass_state               state_d;
  logic [SLOT_BITS-1:0]    slot_q;
  logic [SLOT_BITS-1:0]    slot_d;
  logic                    done_d;
  logic                    last;

  logic [TOTAL_BITS-1:0]   level_q [VOICES];
  adsr_phase               phase_q [VOICES];
  logic [VOICES-1:0]       gate_q;

  logic [TOTAL_BITS-1:0]   a_u;
  logic [TOTAL_BITS-1:0]   d_u;
  logic [TOTAL_BITS-1:0]   r_u;
  logic [TOTAL_BITS-1:0]   s_eff;
  logic [TOTAL_BITS-1:0]   step_level;
  adsr_phase               step_phase;

  // Negative rates are treated as zero; sustain is clamped into 0..ONE.
  always_comb begin
    a_u = a[TOTAL_BITS-1] ? '0 : a;
    d_u = d[TOTAL_BITS-1] ? '0 : d;
    r_u = r[TOTAL_BITS-1] ? '0 : r;
    if (s[TOTAL_BITS-1])          s_eff = '0;
    else if ($unsigned(s) > ONE)  s_eff = ONE;
    else                          s_eff = s;
  end

  // A strobe on the final slot is accepted so back-to-back passes are possible.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    done_d  = 1'b0;
    last    = (slot_q == LAST_SLOT);
    case (state_q)
      PASS_IDLE: begin
        if (sample_en) begin
          state_d = PASS_RUN;
          slot_d  = '0;
        end
      end
      PASS_RUN: begin
        if (last) begin
          done_d  = 1'b1;
          slot_d  = '0;
          state_d = sample_en ? PASS_RUN : PASS_IDLE;
        end else begin
          slot_d  = slot_q + 1'b1;
        end
      end
      default: begin
        state_d = PASS_IDLE;
        slot_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= PASS_IDLE;
      slot_q  <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      done    <= done_d;
    end
  end

  assign busy = (state_q == PASS_RUN);

  adsr_step #(
    .TOTAL_BITS      (TOTAL_BITS),
    .FRACTIONAL_BITS (FRACTIONAL_BITS)
  ) u_step (
    .level      (level_q[slot_q]),
    .phase      (phase_q[slot_q]),
    .gate       (gate[slot_q]),
    .gate_q     (gate_q[slot_q]),
    .legato     (legato),
    .a          (a_u),
    .d          (d_u),
    .s          (s_eff),
    .r          (r_u),
    .next_level (step_level),
    .next_phase (step_phase)
  );

  // Only the voice in the current slot is written; every other voice holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < VOICES; v++) begin
        level_q[v] <= '0;
        phase_q[v] <= IDLE;
      end
      gate_q <= '0;
      out    <= '0;
      active <= '0;
    end else if (state_q == PASS_RUN) begin
      level_q[slot_q] <= step_level;
      phase_q[slot_q] <= step_phase;
      gate_q[slot_q]  <= gate[slot_q];
      out[slot_q]     <= amplitude_from_level(LEVEL_MAX_BITS'(step_level), FRACTIONAL_BITS);
      active[slot_q]  <= (step_phase != IDLE);
    end
  end

endmodule

// File: tb/tb_adsr_poly.sv
// Self-checking bench for adsr_poly: directed envelope walk-through followed
// by randomized patches/gates against a behavioural envelope model.
module tb_adsr_poly;
  import mypackage::*;

  localparam int     NV   = 4;
  localparam longint ONE  = 64'd1 << 32;

  localparam int M_IDLE    = 0;
  localparam int M_ATTACK  = 1;
  localparam int M_DECAY   = 2;
  localparam int M_SUSTAIN = 3;
  localparam int M_RELEASE = 4;

  logic                 clk;
  logic                 reset;
  logic                 sample_en;
  logic signed [47:0]   a;
  logic signed [47:0]   d;
  logic signed [47:0]   s;
  logic signed [47:0]   r;
  logic                 legato;
  logic [NV-1:0]        gate;
  amplitude [NV-1:0]    out_s;
  logic [NV-1:0]        active_s;
  logic                 busy;
  logic                 done;

  int checks;
  int fails;
  int doneCount;

  longint mlevel [NV];
  int     mphase [NV];
  bit     mgq    [NV];

  adsr_poly #(
    .TOTAL_BITS      (48),
    .FRACTIONAL_BITS (32),
    .VOICES          (NV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .a         (a),
    .d         (d),
    .s         (s),
    .r         (r),
    .legato    (legato),
    .gate      (gate),
    .out       (out_s),
    .active    (active_s),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done) doneCount++;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Behavioural envelope: one tick of one voice, straight from the envelope rules.
  function automatic void modelVoice(input int v, input bit g);
    longint lvl, sp, av, dv, rv;
    int ph;
    av  = a;
    dv  = d;
    rv  = r;
    sp  = (s > ONE) ? ONE : longint'(s);
    lvl = mlevel[v];
    ph  = mphase[v];
    if (g && !mgq[v]) begin
      ph = M_ATTACK;
      if (!legato) lvl = 0;
    end
    if (!g && (ph == M_ATTACK || ph == M_DECAY || ph == M_SUSTAIN)) begin
      ph = M_RELEASE;
    end else if (ph == M_IDLE) begin
      lvl = 0;
    end else if (ph == M_ATTACK) begin
      if (lvl + av >= ONE) begin lvl = ONE; ph = M_DECAY; end
      else lvl = lvl + av;
    end else if (ph == M_DECAY) begin
      if (lvl - dv <= sp) begin lvl = sp; ph = M_SUSTAIN; end
      else lvl = lvl - dv;
    end else if (ph == M_SUSTAIN) begin
      lvl = sp;
    end else begin
      if (lvl <= rv) begin lvl = 0; ph = M_IDLE; end
      else lvl = lvl - rv;
    end
    mlevel[v] = lvl;
    mphase[v] = ph;
    mgq[v]    = g;
  endfunction

  function automatic logic [63:0] expVec();
    logic [63:0] e;
    e = '0;
    for (int v = 0; v < NV; v++) begin
      if (mlevel[v] >= ONE) e[v*16 +: 16] = 16'hFFFF;
      else                  e[v*16 +: 16] = 16'(mlevel[v] >> 16);
    end
    return e;
  endfunction

  function automatic logic [63:0] expActive();
    logic [63:0] e;
    e = '0;
    for (int v = 0; v < NV; v++) e[v] = (mphase[v] != M_IDLE);
    return e;
  endfunction

  function automatic void modelReset();
    for (int v = 0; v < NV; v++) begin
      mlevel[v] = 0;
      mphase[v] = M_IDLE;
      mgq[v]    = 1'b0;
    end
  endfunction

  // One full sample period of 8 clocks; optionally fires a stray strobe mid-pass.
  task automatic applyStimulus(input bit extra);
    int dc0;
    @(negedge clk);
    sample_en = 1'b1;
    dc0 = doneCount;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    checkOutput("busy_after_accept", 64'(busy), 64'd1);
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      modelVoice(i, gate[i]);
      checkOutput("out_vector", 64'(out_s), expVec());
      checkOutput("active_vector", 64'(active_s), expActive());
      checkOutput("done_in_pass", 64'(done), 64'(i == NV - 1));
      checkOutput("busy_in_pass", 64'(busy), 64'(i != NV - 1));
      if (extra && i == 1) sample_en = 1'b1;
      if (extra && i == 2) sample_en = 1'b0;
    end
    @(posedge clk);
    #1;
    checkOutput("done_one_cycle", 64'(done), 64'd0);
    checkOutput("busy_after_pass", 64'(busy), 64'd0);
    checkOutput("done_count", 64'(doneCount - dc0), 64'd1);
    @(posedge clk);
    @(posedge clk);
  endtask

  function automatic longint pickRate();
    case ($urandom_range(0, 4))
      0:       return 0;
      1:       return 64'd1 << 28;
      2:       return 64'd1 << 29;
      3:       return 64'd1 << 30;
      default: return 64'd1 << 33;
    endcase
  endfunction

  initial begin
    int dc0;
    checks    = 0;
    fails     = 0;
    doneCount = 0;
    reset     = 1'b0;
    sample_en = 1'b0;
    legato    = 1'b0;
    gate      = '0;
    a = 48'(64'd1 << 30);
    d = 48'(64'd1 << 29);
    s = 48'(64'd1 << 31);
    r = 48'(64'd1 << 29);
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out", 64'(out_s), 64'd0);
    checkOutput("reset_active", 64'(active_s), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] directed envelope on voice 0");
    gate = 4'b0001;
    repeat (4) applyStimulus(1'b0);
    checkOutput("attack_peak", 64'(out_s[0]), 64'hFFFF);
    repeat (4) applyStimulus(1'b0);
    checkOutput("decay_floor", 64'(out_s[0]), 64'h8000);
    repeat (2) applyStimulus(1'b0);
    checkOutput("sustain_hold", 64'(out_s[0]), 64'h8000);
    checkOutput("others_idle", 64'(active_s[3:1]), 64'd0);
    s = 48'(64'd1 << 30);
    applyStimulus(1'b0);
    checkOutput("sustain_track", 64'(out_s[0]), 64'h4000);
    s = 48'(64'd1 << 33);
    applyStimulus(1'b0);
    checkOutput("sustain_clamp", 64'(out_s[0]), 64'hFFFF);
    s = 48'(64'd1 << 31);
    applyStimulus(1'b0);

    gate = 4'b0000;
    applyStimulus(1'b0);
    checkOutput("release_entry", 64'(out_s[0]), 64'h8000);
    applyStimulus(1'b0);
    checkOutput("release_step1", 64'(out_s[0]), 64'h6000);
    applyStimulus(1'b0);
    checkOutput("release_step2", 64'(out_s[0]), 64'h4000);

    legato = 1'b1;
    gate   = 4'b0001;
    applyStimulus(1'b0);
    checkOutput("legato_tick1", 64'(out_s[0]), 64'h8000);
    applyStimulus(1'b0);
    checkOutput("legato_tick2", 64'(out_s[0]), 64'hC000);

    gate = 4'b0000;
    for (int k = 0; k < 20 && !(mphase[0] == M_RELEASE && mlevel[0] == ONE / 4); k++)
      applyStimulus(1'b0);
    checkOutput("release_quarter", 64'(out_s[0]), 64'h4000);
    legato = 1'b0;
    gate   = 4'b0001;
    applyStimulus(1'b0);
    checkOutput("retrigger_tick1", 64'(out_s[0]), 64'h4000);
    applyStimulus(1'b0);
    checkOutput("retrigger_tick2", 64'(out_s[0]), 64'h8000);

    gate = 4'b0000;
    applyStimulus(1'b1);
    for (int k = 0; k < 20 && mphase[0] != M_IDLE; k++)
      applyStimulus(1'b0);
    checkOutput("release_idle_active", 64'(active_s[0]), 64'd0);
    checkOutput("release_idle_out", 64'(out_s[0]), 64'd0);

    $display("[TB] reset in the middle of a pass");
    gate = 4'b1111;
    @(negedge clk);
    sample_en = 1'b1;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midreset_out", 64'(out_s), 64'd0);
    checkOutput("midreset_active", 64'(active_s), 64'd0);
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    checkOutput("midreset_done", 64'(done), 64'd0);
    dc0 = doneCount;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("midreset_no_done", 64'(doneCount - dc0), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    modelReset();
    repeat (3) applyStimulus(1'b0);

    $display("[TB] randomized patches and gates");
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) gate = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        a = 48'(pickRate());
        d = 48'(pickRate());
        r = 48'(pickRate());
        s = 48'(64'($urandom_range(0, 5)) << 30);
      end
      legato = 1'($urandom_range(0, 1));
      applyStimulus(1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
